// File: rtl/mbscore_bus_arbiter.sv
// mbscore_bus_arbiter: round-robin arbiter sharing one req/ack memory bus between N masters.
// Optional MBS_ARB_TIMEOUT_EN: abort a BUSY transaction after TIMEOUT cycles without mem_ack.
module mbscore_bus_arbiter #(
    parameter int N_MASTERS  = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_MASTERS-1:0]             req,
    input  logic [N_MASTERS-1:0]             lock,
    input  logic [N_MASTERS-1:0]             we,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  addr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]  wdata,
    output logic [N_MASTERS-1:0]             gnt,
    output logic [N_MASTERS-1:0]             done,
    output logic                             err,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             busy,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_ack
);

    localparam int IW = $clog2(N_MASTERS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [N_MASTERS-1:0]    gnt_q, gnt_d;
    logic [N_MASTERS-1:0]    done_q, done_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    busy_q, busy_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]           win_q, win_d;
    logic [IW-1:0]           lock_owner_q, lock_owner_d;
    logic                    lock_vld_q, lock_vld_d;

    logic [IW-1:0]           win;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

`ifdef MBS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0]           cnt_q, cnt_d;
`endif

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Winner pick: a requesting lock owner first, else round-robin from rr_ptr+1 (upper group overrides the wrapped group)
    always_comb begin
        win       = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int j = N_MASTERS - 1; j >= 0; j--)
            if (req[j] && j <= int'(rr_ptr_q)) win = IW'(j);
        for (int j = N_MASTERS - 1; j >= 0; j--)
            if (req[j] && j > int'(rr_ptr_q)) win = IW'(j);
        if (lock_vld_q && req[lock_owner_q]) win = lock_owner_q;
        for (int j = 0; j < N_MASTERS; j++)
            if (win == IW'(j)) begin
                sel_we    = we[j];
                sel_addr  = addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata[j*DATA_WIDTH +: DATA_WIDTH];
            end
    end

    // Transaction sequencer: next state and all registered outputs
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        done_d       = done_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        busy_d       = busy_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rr_ptr_d     = rr_ptr_q;
        win_d        = win_q;
        lock_owner_d = lock_owner_q;
        lock_vld_d   = lock_vld_q;
`ifdef MBS_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (lock_vld_q && !req[lock_owner_q]) lock_vld_d = 1'b0;
                if (|req) begin
                    gnt_d       = {{(N_MASTERS-1){1'b0}}, 1'b1} << win;
                    win_d       = win;
                    mem_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_req_d   = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = BUSY;
`ifdef MBS_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    rdata_d   = mem_we_q ? rdata_q : mem_rdata;
                    done_d    = gnt_q;
                    rr_ptr_d  = win_q;
                    state_d   = DONE;
                end
`ifdef MBS_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    mem_req_d = 1'b0;
                    rdata_d   = {DATA_WIDTH{1'b1}};
                    done_d    = gnt_q;
                    err_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                lock_owner_d = win_q;
                lock_vld_d   = |(lock & gnt_q) && !err_q;
                gnt_d        = '0;
                done_d       = '0;
                err_d        = 1'b0;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rr_ptr_q     <= IW'(N_MASTERS - 1);
            win_q        <= '0;
            lock_owner_q <= '0;
            lock_vld_q   <= 1'b0;
`ifdef MBS_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
            lock_owner_q <= lock_owner_d;
            lock_vld_q   <= lock_vld_d;
`ifdef MBS_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mbscore_bus_arbiter.sv
// tb_mbscore_bus_arbiter: table-driven transactions plus hand sequences for round-robin, lock, reset and timeout.
module tb_mbscore_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, lock, we;
    logic [95:0] addr, wdata;
    logic [2:0]  gnt, done;
    logic        err, busy, mem_req, mem_we, mem_ack;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;

    mbscore_bus_arbiter #(.N_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [95:0] a;
        logic [95:0] wd;
        logic [31:0] rd;
        int          dly;
        logic [2:0]  egnt;
        logic [31:0] eaddr;
        logic        ewe;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic next_grant(output logic [2:0] g);
        g = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (mem_req) begin
                g = gnt;
                return;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        req = v.req; we = v.we; addr = v.a; wdata = v.wd; mem_rdata = v.rd;
        step();
        chk("vec_gnt", gnt, v.egnt);
        chk("vec_mem_req", mem_req, 1);
        chk("vec_mem_addr", mem_addr, v.eaddr);
        chk("vec_mem_we", mem_we, v.ewe);
        chk("vec_mem_wdata", mem_wdata, v.ewd);
        chk("vec_busy", busy, 1);
        repeat (v.dly) step();
        chk("vec_no_early_done", done, 0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("vec_done", done, v.egnt);
        chk("vec_done_gnt", gnt, v.egnt);
        chk("vec_err", err, 0);
        chk("vec_rdata", rdata, v.erd);
        chk("vec_mem_req_low", mem_req, 0);
        req = '0;
        step();
        chk("vec_idle_busy", busy, 0);
        chk("vec_idle_gnt", gnt, 0);
        chk("vec_idle_done", done, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  g;
        logic [95:0] a_std, wd_std;
        a_std  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        wd_std = {32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
        tbl[0] = '{3'b010, 3'b000, {32'h300, 32'h40, 32'h100}, wd_std, 32'hDEAD_BEEF, 2,
                   3'b010, 32'h40, 1'b0, 32'hA1A1_A1A1, 32'hDEAD_BEEF};
        tbl[1] = '{3'b111, 3'b000, a_std, wd_std, 32'h1111_1111, 1,
                   3'b100, 32'h300, 1'b0, 32'hA2A2_A2A2, 32'h1111_1111};
        tbl[2] = '{3'b111, 3'b000, a_std, wd_std, 32'h2222_2222, 0,
                   3'b001, 32'h100, 1'b0, 32'hA0A0_A0A0, 32'h2222_2222};
        tbl[3] = '{3'b011, 3'b010, a_std, {32'hA2A2_A2A2, 32'hCAFE_F00D, 32'hA0A0_A0A0}, 32'h9999_9999, 3,
                   3'b010, 32'h200, 1'b1, 32'hCAFE_F00D, 32'h2222_2222};
        tbl[4] = '{3'b101, 3'b000, a_std, wd_std, 32'h3333_3333, 1,
                   3'b100, 32'h300, 1'b0, 32'hA2A2_A2A2, 32'h3333_3333};
        tbl[5] = '{3'b110, 3'b000, a_std, wd_std, 32'h4444_4444, 0,
                   3'b010, 32'h200, 1'b0, 32'hA1A1_A1A1, 32'h4444_4444};

        rst = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) step();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // round-robin with all requesting, ack held high
        rst = 1'b1; step(); rst = 1'b0;
        addr = a_std; wdata = wd_std; we = '0;
        mem_rdata = 32'h5A5A_5A5A; mem_ack = 1'b1; req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            next_grant(g);
            chk("rr_gnt", g, 3'b001 << (i % 3));
        end
        req = '0;
        repeat (2) step();
        chk("rr_idle", busy, 0);

        // lock: 0 first, then 2 three times, then lock drop returns bus to 0
        req = 3'b101; lock = 3'b100;
        next_grant(g); chk("lock_g0", g, 3'b001);
        next_grant(g); chk("lock_g1", g, 3'b100);
        next_grant(g); chk("lock_g2", g, 3'b100);
        next_grant(g); chk("lock_g3", g, 3'b100);
        lock = '0;
        next_grant(g); chk("lock_g4", g, 3'b001);
        req = '0;
        repeat (2) step();
        mem_ack = 1'b0;
        chk("lock_rdata", rdata, 32'h5A5A_5A5A);

        // write with req withdrawn during BUSY
        req = 3'b001; we = 3'b001; wdata = {32'h0, 32'h0, 32'h1234_5678};
        step();
        chk("wr_gnt", gnt, 3'b001);
        req = '0; wdata = {3{32'hBAD0_BAD0}}; addr = {3{32'hFFFF_0000}};
        repeat (2) step();
        chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
        chk("wr_mem_addr", mem_addr, 32'h100);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_busy", busy, 1);
        mem_rdata = 32'hAAAA_5555; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("wr_done", done, 3'b001);
        chk("wr_rdata_kept", rdata, 32'h5A5A_5A5A);
        step();
        chk("wr_done_once", done, 0);
        chk("wr_idle_busy", busy, 0);

        // asynchronous reset in the middle of BUSY
        we = '0; addr = a_std; wdata = wd_std; req = 3'b010;
        step();
        chk("rb_mem_req", mem_req, 1);
        #2 rst = 1'b1; req = '0;
        #1;
        chk("rb_async_gnt", gnt, 0);
        chk("rb_async_busy", busy, 0);
        chk("rb_async_mem_req", mem_req, 0);
        chk("rb_async_mem_addr", mem_addr, 0);
        chk("rb_async_rdata", rdata, 0);
        step();
        rst = 1'b0; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("rb_late_ack_done", done, 0);
        chk("rb_late_ack_busy", busy, 0);
        req = 3'b100;
        step();
        chk("rb_regrant", gnt, 3'b100);
        chk("rb_regrant_addr", mem_addr, 32'h300);
        mem_rdata = 32'h7777_0000; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; req = '0;
        chk("rb_done", done, 3'b100);
        step();

        // no mem_ack: timeout abort if enabled, otherwise wait forever
        req = 3'b001;
        step();
        chk("to_busy", busy, 1);
        req = '0;
        repeat (15) step();
        chk("to_pre_done", done, 0);
        chk("to_pre_mem_req", mem_req, 1);
`ifdef MBS_ARB_TIMEOUT_EN
        step();
        chk("to_done", done, 3'b001);
        chk("to_err", err, 1);
        chk("to_rdata", rdata, 32'hFFFF_FFFF);
        step();
        chk("to_err_once", err, 0);
        chk("to_idle", busy, 0);
`else
        repeat (10) step();
        chk("to_still_busy", busy, 1);
        chk("to_still_req", mem_req, 1);
        chk("to_no_err", err, 0);
        mem_rdata = 32'h0BAD_F00D; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("to_late_done", done, 3'b001);
        chk("to_late_err", err, 0);
        chk("to_late_rdata", rdata, 32'h0BAD_F00D);
        step();
        chk("to_idle", busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
